// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control logic.
// Forward-select encodings, mult/div scoreboard state type, and a register-match helper.
// Pure declarations; no timing or flow control of its own.
package mips_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;  // operand straight from the register file
  localparam logic [1:0] FWD_W  = 2'b01;  // operand from ResultW
  localparam logic [1:0] FWD_M  = 2'b10;  // operand from ALUOutM

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // A source register hits a producer only if the producer writes and the source is not $0.
  function automatic logic reg_hit(input logic [4:0] src, input logic we, input logic [4:0] dst);
    return we && (src != 5'd0) && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle of pipeline-stage register addresses/enables and hazard-unit controls.
// No latency of its own; master is the datapath, slave is the hazard unit.
// No backpressure; stall/flush are level signals consumed in the same cycle.
interface hazard_unit_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       RsD, RtD, RsE, RtE;
  logic [4:0]       WriteRegE, WriteRegM, WriteRegW;
  logic             RegWriteE, RegWriteM, RegWriteW;
  logic             MemtoRegE, MemtoRegM;
  logic             BranchD, MdStartD, MdStartE, MdReadD;
  logic             StallF, StallD, FlushE;
  logic             ForwardAD, ForwardBD;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             MdBusy, MdDone, MdOverrun;
  logic [CNT_W-1:0] StallCount;

  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, MdStartD, MdStartE, MdReadD,
    input  StallF, StallD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE,
           MdBusy, MdDone, MdOverrun, StallCount
  );

  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, MdStartD, MdStartE, MdReadD,
    output StallF, StallD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE,
           MdBusy, MdDone, MdOverrun, StallCount
  );

endinterface

// File: rtl/md_scoreboard.sv
// Busy tracker for the multi-cycle mult/div unit (IDLE/BUSY FSM plus down-counter).
// Busy for MD_LATENCY cycles after the start cycle; done pulses on the last busy cycle.
// Start while busy (except on the done cycle) is dropped and flagged as a sticky overrun.
module md_scoreboard
  import mips_pkg::*;
#(
  parameter int MD_LATENCY = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start_i,
  output logic md_busy_o,
  output logic md_done_o,
  output logic md_overrun_o
);

  localparam logic [7:0] CNT_LOAD = 8'(MD_LATENCY - 1);

  md_state_e  state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       overrun_q, overrun_d;

  // State register: reset drops straight to IDLE, so no done pulse can follow an abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= MD_IDLE;
      cnt_q     <= 8'd0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

  // Next state: a start on the final busy cycle is a legal back-to-back reload.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;
    case (state_q)
      MD_IDLE: begin
        if (md_start_i) begin
          state_d = MD_BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      MD_BUSY: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
          if (md_start_i) overrun_d = 1'b1;
        end else if (md_start_i) begin
          cnt_d = CNT_LOAD;
        end else begin
          state_d = MD_IDLE;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // Outputs: decoded from registered state only.
  always_comb begin
    md_busy_o    = (state_q == MD_BUSY);
    md_done_o    = (state_q == MD_BUSY) && (cnt_q == 8'd0);
    md_overrun_o = overrun_q;
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: forwarding selects, load-use/branch/mult-div stalls, stall counter.
// Forwards and stalls are combinational in the same cycle; the counter updates on the next edge.
// Stall holds F/D and bubbles E; all controls are forced low while reset is high.
module hazard_unit
  import mips_pkg::*;
#(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 16
) (
  input  logic        clk,
  input  logic        reset,
  hazard_unit_if.slave hz
);

  logic             md_busy;
  logic             lwstall, branchstall, mdstall, stall;
  logic [1:0]       fwd_ae, fwd_be;
  logic             fwd_ad, fwd_bd;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  md_scoreboard #(
    .MD_LATENCY (MD_LATENCY)
  ) u_md_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .md_start_i   (hz.MdStartE),
    .md_busy_o    (md_busy),
    .md_done_o    (hz.MdDone),
    .md_overrun_o (hz.MdOverrun)
  );

  // Hazard detection and forwarding; M outranks W because it holds the younger result.
  always_comb begin
    fwd_ae = FWD_RF;
    if (reg_hit(hz.RsE, hz.RegWriteM, hz.WriteRegM))      fwd_ae = FWD_M;
    else if (reg_hit(hz.RsE, hz.RegWriteW, hz.WriteRegW)) fwd_ae = FWD_W;

    fwd_be = FWD_RF;
    if (reg_hit(hz.RtE, hz.RegWriteM, hz.WriteRegM))      fwd_be = FWD_M;
    else if (reg_hit(hz.RtE, hz.RegWriteW, hz.WriteRegW)) fwd_be = FWD_W;

    fwd_ad = reg_hit(hz.RsD, hz.RegWriteM, hz.WriteRegM);
    fwd_bd = reg_hit(hz.RtD, hz.RegWriteM, hz.WriteRegM);

    lwstall = reg_hit(hz.RsD, hz.MemtoRegE, hz.RtE) ||
              reg_hit(hz.RtD, hz.MemtoRegE, hz.RtE);

    branchstall = hz.BranchD &&
                  (reg_hit(hz.RsD, hz.RegWriteE, hz.WriteRegE) ||
                   reg_hit(hz.RtD, hz.RegWriteE, hz.WriteRegE) ||
                   reg_hit(hz.RsD, hz.MemtoRegM, hz.WriteRegM) ||
                   reg_hit(hz.RtD, hz.MemtoRegM, hz.WriteRegM));

    mdstall = (hz.MdReadD || hz.MdStartD) && (md_busy || hz.MdStartE);

    stall = !reset && (lwstall || branchstall || mdstall);

    if (reset) begin
      fwd_ae = FWD_RF;
      fwd_be = FWD_RF;
      fwd_ad = 1'b0;
      fwd_bd = 1'b0;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign hz.StallF     = stall;
  assign hz.StallD     = stall;
  assign hz.FlushE     = stall;
  assign hz.ForwardAE  = fwd_ae;
  assign hz.ForwardBE  = fwd_be;
  assign hz.ForwardAD  = fwd_ad;
  assign hz.ForwardBD  = fwd_bd;
  assign hz.MdBusy     = md_busy;
  assign hz.StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios then randomized traffic vs a reference model.
// Inputs change 1 time unit after the rising edge; outputs are compared 3 units later.
// The model tracks remaining mult/div busy cycles and the stall count as plain integers.
module tb_hazard_unit;
  localparam int LAT  = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  // reference model state
  int   m_rem;   // busy cycles still to come, including the current one
  int   m_cnt;
  bit   m_ovr;

  hazard_unit_if #(.CNT_W(CW)) hif ();

  hazard_unit #(.MD_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_in();
    hif.RsD = 0; hif.RtD = 0; hif.RsE = 0; hif.RtE = 0;
    hif.WriteRegE = 0; hif.WriteRegM = 0; hif.WriteRegW = 0;
    hif.RegWriteE = 0; hif.RegWriteM = 0; hif.RegWriteW = 0;
    hif.MemtoRegE = 0; hif.MemtoRegM = 0;
    hif.BranchD = 0; hif.MdStartD = 0; hif.MdStartE = 0; hif.MdReadD = 0;
  endtask

  task automatic model_reset();
    m_rem = 0; m_cnt = 0; m_ovr = 0;
  endtask

  function automatic bit hit(input logic [4:0] src, input logic [4:0] dst);
    return (src != 0) && (src == dst);
  endfunction

  function automatic bit exp_stall();
    bit lw, br, md;
    if (reset) return 0;
    lw = hif.MemtoRegE && (hit(hif.RsD, hif.RtE) || hit(hif.RtD, hif.RtE));
    br = hif.BranchD &&
         ((hif.RegWriteE && (hit(hif.RsD, hif.WriteRegE) || hit(hif.RtD, hif.WriteRegE))) ||
          (hif.MemtoRegM && (hit(hif.RsD, hif.WriteRegM) || hit(hif.RtD, hif.WriteRegM))));
    md = (hif.MdReadD || hif.MdStartD) && ((m_rem > 0) || hif.MdStartE);
    return lw || br || md;
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] src);
    if (reset) return 2'd0;
    if (hif.RegWriteM && hit(src, hif.WriteRegM)) return 2'd2;
    if (hif.RegWriteW && hit(src, hif.WriteRegW)) return 2'd1;
    return 2'd0;
  endfunction

  task automatic check_outputs();
    bit s;
    s = exp_stall();
    chk("StallF", hif.StallF, s);
    chk("StallD", hif.StallD, s);
    chk("FlushE", hif.FlushE, s);
    chk("ForwardAE", hif.ForwardAE, exp_fwd(hif.RsE));
    chk("ForwardBE", hif.ForwardBE, exp_fwd(hif.RtE));
    chk("ForwardAD", hif.ForwardAD, !reset && hif.RegWriteM && hit(hif.RsD, hif.WriteRegM));
    chk("ForwardBD", hif.ForwardBD, !reset && hif.RegWriteM && hit(hif.RtD, hif.WriteRegM));
    chk("MdBusy", hif.MdBusy, m_rem > 0);
    chk("MdDone", hif.MdDone, m_rem == 1);
    chk("MdOverrun", hif.MdOverrun, m_ovr);
    chk("StallCount", hif.StallCount, m_cnt);
  endtask

  task automatic settle();
    #3;
  endtask

  // advance one clock and update the model with the inputs seen at the edge
  task automatic tick();
    bit s;
    s = exp_stall();
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      if (s && m_cnt < CMAX) m_cnt++;
      if (hif.MdStartE && m_rem <= 1) begin
        m_rem = LAT;
      end else begin
        if (hif.MdStartE) m_ovr = 1;
        if (m_rem > 0) m_rem--;
      end
    end
    #1;
  endtask

  task automatic cyc();
    settle();
    check_outputs();
    tick();
  endtask

  initial begin
    // reset with a live load-use hazard on the inputs: everything must read zero
    reset = 1'b1;
    model_reset();
    clear_in();
    hif.MemtoRegE = 1; hif.RtE = 5'd9; hif.RsD = 5'd9;
    hif.RegWriteM = 1; hif.WriteRegM = 5'd9; hif.RsE = 5'd9;
    settle();
    chk("rst_stall", hif.StallF, 0);
    chk("rst_fwd", hif.ForwardAE, 0);
    check_outputs();
    tick();
    reset = 1'b0;

    // 1: ALU RAW, M beats W, then W only, then $0
    clear_in();
    hif.RegWriteM = 1; hif.WriteRegM = 5'd8; hif.RsE = 5'd8;
    hif.RegWriteW = 1; hif.WriteRegW = 5'd8;
    settle(); chk("t1_m_wins", hif.ForwardAE, 2'b10); check_outputs(); tick();
    hif.RegWriteM = 0;
    settle(); chk("t1_w_only", hif.ForwardAE, 2'b01); check_outputs(); tick();
    hif.RegWriteM = 1; hif.WriteRegM = 5'd0; hif.RsE = 5'd0; hif.WriteRegW = 5'd0;
    settle(); chk("t1_r0", hif.ForwardAE, 2'b00); check_outputs(); tick();

    // 2: load-use, one stall cycle then load sits in M
    clear_in();
    hif.MemtoRegE = 1; hif.RegWriteE = 1; hif.WriteRegE = 5'd9; hif.RtE = 5'd9; hif.RsD = 5'd9;
    settle(); chk("t2_stall", hif.StallF, 1); check_outputs(); tick();
    clear_in();
    hif.MemtoRegM = 1; hif.RegWriteM = 1; hif.WriteRegM = 5'd9; hif.RsD = 5'd9;
    settle(); chk("t2_nostall", hif.StallF, 0); chk("t2_cnt", hif.StallCount, 1);
    check_outputs(); tick();

    // 3: branch on a value still in E, then forwarded from M
    clear_in();
    hif.BranchD = 1; hif.RsD = 5'd16; hif.RegWriteE = 1; hif.WriteRegE = 5'd16;
    settle(); chk("t3_stall", hif.StallD, 1); check_outputs(); tick();
    clear_in();
    hif.BranchD = 1; hif.RsD = 5'd16; hif.RegWriteM = 1; hif.WriteRegM = 16;
    settle(); chk("t3_nostall", hif.StallD, 0); chk("t3_fwdad", hif.ForwardAD, 1);
    check_outputs(); tick();

    // 4: mult/div start with mfhi held in D
    clear_in();
    hif.MdStartE = 1; hif.MdReadD = 1;
    settle(); chk("t4_stall0", hif.FlushE, 1); check_outputs(); tick();
    hif.MdStartE = 0;
    for (int k = 1; k <= LAT; k++) begin
      settle();
      chk("t4_busy", hif.MdBusy, 1);
      chk("t4_done", hif.MdDone, k == LAT);
      chk("t4_stall", hif.StallF, 1);
      check_outputs();
      tick();
    end
    settle(); chk("t4_release", hif.StallF, 0); chk("t4_idle", hif.MdBusy, 0);
    check_outputs(); tick();

    // 5a: overrun two cycles after start; done still on schedule
    clear_in();
    hif.MdStartE = 1; cyc();
    hif.MdStartE = 0; cyc();
    hif.MdStartE = 1; cyc();
    hif.MdStartE = 0;
    settle(); chk("t5_ovr", hif.MdOverrun, 1); check_outputs(); tick();
    settle(); chk("t5_done", hif.MdDone, 1); check_outputs(); tick();
    // 5b: async reset mid-busy, observed before any clock edge
    hif.MdStartE = 1; cyc();
    hif.MdStartE = 0; hif.MdReadD = 1; cyc();
    settle();
    reset = 1'b1;
    model_reset();
    #1;
    chk("t5_rst_busy", hif.MdBusy, 0);
    chk("t5_rst_ovr", hif.MdOverrun, 0);
    chk("t5_rst_cnt", hif.StallCount, 0);
    chk("t5_rst_stall", hif.StallF, 0);
    check_outputs();
    tick();
    reset = 1'b0;
    clear_in();
    cyc();

    // 6: 20 consecutive load-use stalls saturate the counter
    hif.MemtoRegE = 1; hif.RtE = 5'd3; hif.RtD = 5'd3;
    for (int k = 0; k < 20; k++) cyc();
    clear_in();
    settle(); chk("t6_sat", hif.StallCount, CMAX); check_outputs(); tick();

    // randomized traffic; small register set so matches are frequent
    reset = 1'b1; model_reset(); tick(); reset = 1'b0;
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      if (reset) model_reset();
      hif.RsD = 5'($urandom_range(0, 3));
      hif.RtD = 5'($urandom_range(0, 3));
      hif.RsE = 5'($urandom_range(0, 3));
      hif.RtE = 5'($urandom_range(0, 3));
      hif.WriteRegE = 5'($urandom_range(0, 3));
      hif.WriteRegM = 5'($urandom_range(0, 3));
      hif.WriteRegW = 5'($urandom_range(0, 3));
      hif.RegWriteE = 1'($urandom_range(0, 1));
      hif.RegWriteM = 1'($urandom_range(0, 1));
      hif.RegWriteW = 1'($urandom_range(0, 1));
      hif.MemtoRegE = ($urandom_range(0, 3) == 0);
      hif.MemtoRegM = ($urandom_range(0, 3) == 0);
      hif.BranchD   = ($urandom_range(0, 3) == 0);
      hif.MdStartD  = ($urandom_range(0, 7) == 0);
      hif.MdStartE  = ($urandom_range(0, 5) == 0);
      hif.MdReadD   = ($urandom_range(0, 3) == 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
